seq_det_scheduler: RTL

Word-level sequencer that drives the `sequence_detector` datapath. It accepts parallel test words over a valid/ready handshake and serializes each word MSB-first onto the detector's `sig_to_test`, with `ena` asserted. It counts `z` pulses while the word is shifted out and returns one hit count per word over a second valid/ready handshake. It sits between a host or test harness and the single detector instance, and owns the detector's `rst` and `ena` control.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_scheduler_sat_counter.sv | 34 +++
 rtl/seq_det_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the sequence-detector word scheduler.
package seq_det_pkg;

  localparam int SEQ_WORD_W = 24;
  localparam int SEQ_CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_REPORT
  } sched_state_t;

endpackage

// File: rtl/seq_det_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_scheduler.sv
// Serializes test words MSB-first into the sequence detector and returns a hit count per word.
// Optional SEQ_SCHED_CLEAR_EN: resets the detector in a CLEAR cycle before every word.
//
// state    | meaning
// S_IDLE   | waiting for a word, in_ready high
// S_CLEAR  | one-cycle detector reset before shifting (SEQ_SCHED_CLEAR_EN only)
// S_SHIFT  | presenting one bit per cycle with det_ena high, counting det_z
// S_REPORT | holding res_valid/res_count until res_ready
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int WORD_W = SEQ_WORD_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_word_i,
  output logic              in_ready_o,
  input  logic              abort_i,
  output logic              det_rst_o,
  output logic              det_ena_o,
  output logic              det_sig_o,
  input  logic              det_z_i,
  output logic              res_valid_o,
  output logic [CNT_W-1:0]  res_count_o,
  input  logic              res_ready_i,
  output logic              busy_o
);

  localparam int              BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  sched_state_t      state_q;
  logic [WORD_W-1:0] sr_q;
  logic [BIT_W-1:0]  bit_q;
  logic              det_rst_q;
  logic              det_ena_q;
  logic              det_sig_q;
  logic              res_valid_q;
  logic              busy_q;

  logic              accept;
  logic              abort_act;
  logic              hit_clr;
  logic              hit_inc;
  logic [CNT_W-1:0]  hit_cnt;

  assign in_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign abort_act  = abort_i && ((state_q == S_CLEAR) || (state_q == S_SHIFT));
  assign hit_clr    = accept || abort_act;
  assign hit_inc    = (state_q == S_SHIFT) && det_z_i;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (hit_clr),
    .inc_i (hit_inc),
    .cnt_o (hit_cnt)
  );

  // det_sig_q always carries the bit being presented; sr_q holds the bits still to come.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_q       <= '0;
      det_rst_q   <= 1'b1;
      det_ena_q   <= 1'b0;
      det_sig_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      det_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            bit_q  <= '0;
`ifdef SEQ_SCHED_CLEAR_EN
            state_q   <= S_CLEAR;
            sr_q      <= in_word_i;
            det_rst_q <= 1'b1;
`else
            state_q   <= S_SHIFT;
            sr_q      <= {in_word_i[WORD_W-2:0], 1'b0};
            det_sig_q <= in_word_i[WORD_W-1];
            det_ena_q <= 1'b1;
`endif
          end
        end
        S_CLEAR: begin
          if (abort_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            det_rst_q <= 1'b1;
          end else begin
            state_q   <= S_SHIFT;
            sr_q      <= {sr_q[WORD_W-2:0], 1'b0};
            det_sig_q <= sr_q[WORD_W-1];
            det_ena_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (abort_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            det_rst_q <= 1'b1;
            det_ena_q <= 1'b0;
            det_sig_q <= 1'b0;
          end else if (bit_q == LAST_BIT) begin
            state_q     <= S_REPORT;
            det_ena_q   <= 1'b0;
            det_sig_q   <= 1'b0;
            res_valid_q <= 1'b1;
          end else begin
            bit_q     <= bit_q + BIT_W'(1);
            sr_q      <= {sr_q[WORD_W-2:0], 1'b0};
            det_sig_q <= sr_q[WORD_W-1];
          end
        end
        S_REPORT: begin
          if (res_ready_i) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign det_rst_o   = det_rst_q;
  assign det_ena_o   = det_ena_q;
  assign det_sig_o   = det_sig_q;
  assign res_valid_o = res_valid_q;
  assign res_count_o = hit_cnt;
  assign busy_o      = busy_q;

endmodule
